// File: rtl/decode_rename_queue.sv
// Decode-to-rename instruction buffer: accepts up to two uops per cycle and presents
// the oldest two in order, absorbing rename back-pressure and flushing on recover.

package decode_rename_queue_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } uop_bundle_t;
endpackage

module decode_rename_queue
  import decode_rename_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_recover,
  input  uop_bundle_t       i_inst0_in,
  input  uop_bundle_t       i_inst1_in,
  output logic              o_in_ready,
  output uop_bundle_t       o_inst0_out,
  output uop_bundle_t       o_inst1_out,
  input  logic              i_out_ready,
  output logic [PTR_W:0]    o_count
);

  uop_bundle_t      r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic             w_in_ready;
  logic [1:0]       w_enq_n;
  logic [1:0]       w_deq_n;
  logic [PTR_W-1:0] w_head1;
  logic [PTR_W-1:0] w_tail1;

  // Pairs are never split, so one free slot is not enough to accept input.
  assign w_in_ready = (r_count <= (PTR_W+1)'(DEPTH - 2));
  assign w_head1    = r_head + PTR_W'(1);
  assign w_tail1    = r_tail + PTR_W'(1);

  always_comb begin
    w_enq_n = 2'd0;
    w_deq_n = 2'd0;
    if (!i_recover) begin
      if (w_in_ready) begin
        w_enq_n = {1'b0, i_inst0_in.valid} + {1'b0, i_inst1_in.valid};
      end
      if (i_out_ready) begin
        if (r_count >= (PTR_W+1)'(2)) begin
          w_deq_n = 2'd2;
        end else if (r_count != '0) begin
          w_deq_n = 2'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_recover) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_deq_n);
      r_tail  <= r_tail + PTR_W'(w_enq_n);
      r_count <= r_count + (PTR_W+1)'(w_enq_n) - (PTR_W+1)'(w_deq_n);
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (w_enq_n == 2'd2) begin
        r_mem[r_tail]  <= i_inst0_in;
        r_mem[w_tail1] <= i_inst1_in;
      end else if (w_enq_n == 2'd1) begin
        r_mem[r_tail]  <= i_inst0_in.valid ? i_inst0_in : i_inst1_in;
      end
    end
  end

  always_comb begin
    o_inst0_out = '0;
    o_inst1_out = '0;
    if (!i_recover) begin
      if (r_count != '0) begin
        o_inst0_out       = r_mem[r_head];
        o_inst0_out.valid = 1'b1;
      end
      if (r_count >= (PTR_W+1)'(2)) begin
        o_inst1_out       = r_mem[w_head1];
        o_inst1_out.valid = 1'b1;
      end
    end
  end

  assign o_in_ready = w_in_ready;
  assign o_count    = r_count;

`ifdef DEBUG
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (r_count <= (PTR_W+1)'(DEPTH));
      assert (!(w_enq_n != 2'd0 && !w_in_ready));
    end
  end
`endif

endmodule

// File: tb/tb_decode_rename_queue.sv
// Randomized and directed bench for decode_rename_queue, checked against a queue-based
// model of the buffer's occupancy and ordering rules.

module tb_decode_rename_queue;
  import decode_rename_queue_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PTR_W = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           recover;
  uop_bundle_t    inst0_in;
  uop_bundle_t    inst1_in;
  logic           in_ready;
  uop_bundle_t    inst0_out;
  uop_bundle_t    inst1_out;
  logic           out_ready;
  logic [PTR_W:0] count;

  always #5 clk = ~clk;

  decode_rename_queue #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_recover   (recover),
    .i_inst0_in  (inst0_in),
    .i_inst1_in  (inst1_in),
    .o_in_ready  (in_ready),
    .o_inst0_out (inst0_out),
    .o_inst1_out (inst1_out),
    .i_out_ready (out_ready),
    .o_count     (count)
  );

  uop_bundle_t model_q[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic uop_bundle_t mk(input logic [31:0] pc);
    uop_bundle_t u;
    u.valid = 1'b1;
    u.pc    = pc;
    u.instr = $urandom;
    return u;
  endfunction

  // Invalid slot with garbage payload, to expose compaction mistakes.
  function automatic uop_bundle_t inv();
    uop_bundle_t u;
    u.valid = 1'b0;
    u.pc    = $urandom;
    u.instr = $urandom;
    return u;
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    recover   = 1'b0;
    out_ready = 1'b0;
    inst0_in  = '0;
    inst1_in  = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_q.delete();
  endtask

  // One clock: drive, compare at the falling edge, advance the model, move past the edge.
  task automatic cycle(input uop_bundle_t a, input uop_bundle_t b, input logic ordy,
                       input logic rec);
    uop_bundle_t e0;
    uop_bundle_t e1;
    int sz;
    bit accept;
    inst0_in  = a;
    inst1_in  = b;
    out_ready = ordy;
    recover   = rec;
    @(negedge clk);
    sz = model_q.size();
    e0 = '0;
    e1 = '0;
    if (!rec && sz >= 1) begin e0 = model_q[0]; e0.valid = 1'b1; end
    if (!rec && sz >= 2) begin e1 = model_q[1]; e1.valid = 1'b1; end
    check("inst0_out", inst0_out, e0);
    check("inst1_out", inst1_out, e1);
    check("count", count, sz);
    check("in_ready", in_ready, (DEPTH - sz) >= 2);
    if (rec) begin
      model_q.delete();
    end else begin
      accept = (DEPTH - sz) >= 2;
      if (ordy) repeat ((sz >= 2) ? 2 : sz) void'(model_q.pop_front());
      if (accept) begin
        if (a.valid) model_q.push_back(a);
        if (b.valid) model_q.push_back(b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();

    // Idle after reset.
    cycle(inv(), inv(), 1'b0, 1'b0);
    cycle('0, '0, 1'b1, 1'b0);

    // Fill without drain, then try one more pair.
    for (int k = 0; k < 4; k++) begin
      cycle(mk(32'(8 * k)), mk(32'(8 * k + 4)), 1'b0, 1'b0);
      if (k == 2) begin
        check("fill_count6", count, 6);
        check("fill_ready6", in_ready, 1'b1);
      end
    end
    check("full_count", count, 8);
    check("full_ready", in_ready, 1'b0);
    cycle(mk(32'h100), mk(32'h104), 1'b0, 1'b0);
    check("drop_count", count, 8);

    // Drain in order.
    for (int k = 0; k < 4; k++) cycle(inv(), inv(), 1'b1, 1'b0);
    check("drained", count, 0);

    // Lone younger slot, then a pair, with rename draining.
    cycle(inv(), mk(32'h40), 1'b1, 1'b0);
    cycle(mk(32'h44), mk(32'h48), 1'b1, 1'b0);
    cycle(inv(), inv(), 1'b1, 1'b0);
    cycle(inv(), inv(), 1'b1, 1'b0);

    // Steady pair traffic across the pointer wrap.
    for (int k = 0; k < 20; k++) cycle(mk(32'h200 + 32'(8 * k)), mk(32'h204 + 32'(8 * k)),
                                       1'b1, 1'b0);
    check("wrap_count", count, 2);
    cycle(inv(), inv(), 1'b1, 1'b0);

    // Recover mid-stream at count 5.
    do_reset();
    cycle(mk(32'h300), mk(32'h304), 1'b0, 1'b0);
    cycle(mk(32'h308), mk(32'h30c), 1'b0, 1'b0);
    cycle(mk(32'h310), inv(), 1'b0, 1'b0);
    check("pre_recover", count, 5);
    cycle(mk(32'h400), mk(32'h404), 1'b1, 1'b1);
    check("post_recover", count, 0);
    cycle(inv(), inv(), 1'b1, 1'b0);

    // Random traffic with occasional recover and reset.
    for (int k = 0; k < 500; k++) begin
      uop_bundle_t a;
      uop_bundle_t b;
      a = ($urandom_range(0, 3) != 0) ? mk($urandom) : inv();
      b = ($urandom_range(0, 3) != 0) ? mk($urandom) : inv();
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        cycle(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
